// File: rtl/mem_pkg.sv
// Shared types and address helpers for the multi-port register memory (mem_nr2w).
// Helpers take the address zero-extended to 64 bits so that any ADDR_W up to 64 can share them.
package mem_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int nbytes(input int width);
        return width / BYTE_W;
    endfunction

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // The word index is taken from the address bits above the byte offset.
    function automatic logic [63:0] word_idx(input logic [63:0] addr, input int iw);
        return (addr >> 2) & ((64'd1 << iw) - 64'd1);
    endfunction

    function automatic logic in_range(input logic [63:0] addr, input int depth);
        return (addr >> 2) < 64'(unsigned'(depth));
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// After reset, this sequencer zeroes the memory one word per cycle.
// It holds busy high until every word has been cleared.
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     busy,
    output logic                     clr_we,
    output logic [idx_w(DEPTH)-1:0]  clr_idx
);

    localparam int IDX_W = idx_w(DEPTH);

    state_t           r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end
                end
                READY: ;
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign busy    = r_busy;
    assign clr_we  = r_busy;
    assign clr_idx = r_cnt;

endmodule

// File: rtl/mem_nr2w.sv
// Register memory with NRD registered read ports and two byte-enabled write ports; port 1 wins per byte.
// Define MEM_BYPASS_EN for write-first reads. Without it, a read in the same cycle as a write to that word sees the old word.
module mem_nr2w
    import mem_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int NRD    = 2,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*WIDTH-1:0]    rd_dout,
    input  logic [ADDR_W-1:0]       wr_addr0,
    input  logic [ADDR_W-1:0]       wr_addr1,
    input  logic [WIDTH-1:0]        wr_din0,
    input  logic [WIDTH-1:0]        wr_din1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [WIDTH/8-1:0]      wr_be0,
    input  logic [WIDTH/8-1:0]      wr_be1,
    output logic                    busy,
    output logic                    addr_err
);

    localparam int NBYTES = nbytes(WIDTH);
    localparam int IDX_W  = idx_w(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [NRD*WIDTH-1:0] r_rd_dout;
    logic                 r_addr_err;

    logic                 w_busy;
    logic                 w_clr_we;
    logic [IDX_W-1:0]     w_clr_idx;
    logic [IDX_W-1:0]     w_idx0, w_idx1;
    logic                 w_wr0, w_wr1;
    logic [WIDTH-1:0]     w_new0, w_new1;
    logic [IDX_W-1:0]     w_rd_idx [NRD];
    logic [WIDTH-1:0]     w_rd_val [NRD];
    logic                 w_err;

    mem_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .clk     (clk),
        .rst     (rst),
        .busy    (w_busy),
        .clr_we  (w_clr_we),
        .clr_idx (w_clr_idx)
    );

    // Each write port produces the fully merged word it would store, so same-word writes agree.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_idx0 = IDX_W'(word_idx(64'(wr_addr0), IDX_W));
        w_idx1 = IDX_W'(word_idx(64'(wr_addr1), IDX_W));
        w_wr0  = ~rst & ~w_busy & we0 & in_range(64'(wr_addr0), DEPTH);
        w_wr1  = ~rst & ~w_busy & we1 & in_range(64'(wr_addr1), DEPTH);
        w_new0 = r_mem[w_idx0];
        w_new1 = r_mem[w_idx1];
        for (int b = 0; b < NBYTES; b++) begin
            if (w_wr0 && wr_be0[b]) begin
                w_new0[b*BYTE_W +: BYTE_W] = wr_din0[b*BYTE_W +: BYTE_W];
                if (w_idx1 == w_idx0) w_new1[b*BYTE_W +: BYTE_W] = wr_din0[b*BYTE_W +: BYTE_W];
            end
            if (w_wr1 && wr_be1[b]) begin
                w_new1[b*BYTE_W +: BYTE_W] = wr_din1[b*BYTE_W +: BYTE_W];
                if (w_idx0 == w_idx1) w_new0[b*BYTE_W +: BYTE_W] = wr_din1[b*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        w_err = (we0 & ~w_busy & ((wr_addr0[1:0] != 2'b00) | ~in_range(64'(wr_addr0), DEPTH)))
              | (we1 & ~w_busy & ((wr_addr1[1:0] != 2'b00) | ~in_range(64'(wr_addr1), DEPTH)));
        for (int k = 0; k < NRD; k++) begin
            w_rd_idx[k] = IDX_W'(word_idx(64'(rd_addr[k*ADDR_W +: ADDR_W]), IDX_W));
            w_rd_val[k] = r_mem[w_rd_idx[k]];
`ifdef MEM_BYPASS_EN
            if (w_wr1 && w_idx1 == w_rd_idx[k])      w_rd_val[k] = w_new1;
            else if (w_wr0 && w_idx0 == w_rd_idx[k]) w_rd_val[k] = w_new0;
`endif
            if (!in_range(64'(rd_addr[k*ADDR_W +: ADDR_W]), DEPTH)) w_rd_val[k] = '0;
            if (rd_addr[k*ADDR_W +: 2] != 2'b00 || !in_range(64'(rd_addr[k*ADDR_W +: ADDR_W]), DEPTH))
                w_err = 1'b1;
        end
    end

    // NOTE: the array itself has no reset; the clear sequencer zeroes it word by word instead.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else begin
            if (w_wr0) r_mem[w_idx0] <= w_new0;
            if (w_wr1) r_mem[w_idx1] <= w_new1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_dout  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_err;
            for (int k = 0; k < NRD; k++)
                r_rd_dout[k*WIDTH +: WIDTH] <= w_busy ? '0 : w_rd_val[k];
        end
    end

    assign rd_dout  = r_rd_dout;
    assign addr_err = r_addr_err;
    assign busy     = w_busy;

endmodule
